// File: rtl/clock_divider_ctrl_if.sv
// Divisor configuration channel: valid/ready transfer of a new divide value.
interface clock_divider_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] cfg_m;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (output cfg_m, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_m, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/clock_divider_ctrl.sv
// Programmable clock divider with glitch-free divisor updates: a new divisor
// is latched through a valid/ready channel and applied only at a full-period boundary.
module clock_divider_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEFAULT_M = 2499
) (
  input  logic             basys_clock,
  input  logic             reset,
  input  logic             enable,
  clock_divider_ctrl_if.slave cfg,
  output logic [WIDTH-1:0] active_m,
  output logic             desired_clock,
  output logic             tick,
  output logic             cfg_pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] pending_m_q, pending_m_d;
  logic [WIDTH-1:0] active_m_d;
  logic             desired_clock_d;
  logic             tick_d;
  logic             cfg_pending_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic             transfer;
  logic             at_top;
  logic [WIDTH-1:0] step_count;
  logic             step_clock;
  logic             step_tick;

  assign cfg.cfg_ready = cfg_ready_q;
  assign transfer      = cfg.cfg_valid && cfg_ready_q;
  assign at_top        = (count_q == active_m);

  // One counting step of the divider; count never passes active_m, so no wrap.
  always_comb begin
    step_count = count_q + WIDTH'(1);
    step_clock = desired_clock;
    step_tick  = 1'b0;
    if (at_top) begin
      step_count = '0;
      step_clock = !desired_clock;
      step_tick  = !desired_clock;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    desired_clock_d = desired_clock;
    tick_d          = 1'b0;
    active_m_d      = active_m;
    pending_m_d     = pending_m_q;
    cfg_pending_d   = cfg_pending;

    unique case (state_q)
      IDLE: begin
        count_d         = '0;
        desired_clock_d = 1'b0;
        if (cfg_pending) begin
          // Divisor accepted while idle takes effect one cycle later
          active_m_d    = pending_m_q;
          cfg_pending_d = 1'b0;
          state_d       = enable ? RUN : IDLE;
        end else if (enable) begin
          state_d         = RUN;
          count_d         = step_count;
          desired_clock_d = step_clock;
          tick_d          = step_tick;
        end
      end
      RUN, PEND: begin
        if (!enable) begin
          state_d         = IDLE;
          count_d         = '0;
          desired_clock_d = 1'b0;
          if (cfg_pending) begin
            active_m_d    = pending_m_q;
            cfg_pending_d = 1'b0;
          end
        end else begin
          count_d         = step_count;
          desired_clock_d = step_clock;
          tick_d          = step_tick;
          // Falling toggle closes a full period: safe point to swap divisor
          if (state_q == PEND && at_top && desired_clock) begin
            active_m_d    = pending_m_q;
            cfg_pending_d = 1'b0;
            state_d       = RUN;
          end
        end
      end
      default: begin
        state_d         = IDLE;
        count_d         = '0;
        desired_clock_d = 1'b0;
      end
    endcase

    if (transfer) begin
      pending_m_d   = cfg.cfg_m;
      cfg_pending_d = 1'b1;
      if (enable && state_d == RUN) state_d = PEND;
    end

    cfg_ready_d = !cfg_pending_d;
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      desired_clock <= 1'b0;
      tick          <= 1'b0;
      active_m      <= WIDTH'(DEFAULT_M);
      pending_m_q   <= '0;
      cfg_pending   <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      desired_clock <= desired_clock_d;
      tick          <= tick_d;
      active_m      <= active_m_d;
      pending_m_q   <= pending_m_d;
      cfg_pending   <= cfg_pending_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Self-checking bench for clock_divider_ctrl: directed scenarios plus random
// traffic against a period-position reference model.
module tb_clock_divider_ctrl;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEFAULT_M = 2499;

  logic             basys_clock = 1'b0;
  logic             reset       = 1'b1;
  logic             enable      = 1'b0;
  logic [WIDTH-1:0] active_m;
  logic             desired_clock;
  logic             tick;
  logic             cfg_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: position within the current output period, divisor, pending slot
  longint m_act;
  longint m_pend;
  longint pos;
  bit     run;
  bit     pend;

  clock_divider_ctrl_if #(.WIDTH(WIDTH)) cfg_bus ();

  clock_divider_ctrl #(
    .WIDTH    (WIDTH),
    .DEFAULT_M(DEFAULT_M)
  ) dut (
    .basys_clock  (basys_clock),
    .reset        (reset),
    .enable       (enable),
    .cfg          (cfg_bus.slave),
    .active_m     (active_m),
    .desired_clock(desired_clock),
    .tick         (tick),
    .cfg_pending  (cfg_pending)
  );

  always #5 basys_clock = ~basys_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_act  = longint'(DEFAULT_M);
    m_pend = 0;
    pos    = 0;
    run    = 1'b0;
    pend   = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit v, input logic [WIDTH-1:0] cm);
    bit xfer;
    xfer = v && !pend;
    if (!run && pend) begin
      m_act = m_pend;
      pend  = 1'b0;
      pos   = 0;
      run   = en;
    end else if (!en) begin
      if (pend) begin
        m_act = m_pend;
        pend  = 1'b0;
      end
      run = 1'b0;
      pos = 0;
    end else begin
      run = 1'b1;
      pos++;
      if (pos == 2 * (m_act + 1)) begin
        pos = 0;
        if (pend) begin
          m_act = m_pend;
          pend  = 1'b0;
        end
      end
    end
    if (xfer) begin
      pend   = 1'b1;
      m_pend = longint'(cm);
    end
  endfunction

  task automatic compare_all();
    bit exp_clk;
    bit exp_tick;
    exp_clk  = run && (pos > m_act);
    exp_tick = run && (pos == m_act + 1);
    check("desired_clock", 64'(desired_clock), 64'(exp_clk));
    check("tick",          64'(tick),          64'(exp_tick));
    check("active_m",      64'(active_m),      64'(m_act));
    check("cfg_pending",   64'(cfg_pending),   64'(pend));
    check("cfg_ready",     64'(cfg_bus.cfg_ready), 64'(!pend));
  endtask

  task automatic step(input bit en, input bit v, input logic [WIDTH-1:0] cm);
    enable            = en;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_m     = cm;
    @(posedge basys_clock);
    model_step(en, v, cm);
    @(negedge basys_clock);
    compare_all();
  endtask

  task automatic do_reset();
    enable            = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    reset             = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(negedge basys_clock);
    reset = 1'b0;
  endtask

  task automatic idle_steps(input bit en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, WIDTH'(0));
  endtask

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_m     = '0;
    @(negedge basys_clock);
    do_reset();

    // Default divisor, then a mid-low-half request for divisor 4
    idle_steps(1'b1, 1000);
    step(1'b1, 1'b1, WIDTH'(4));
    idle_steps(1'b1, 4100);
    check("active_m_after_apply", 64'(active_m), 64'(4));

    // Divisor 0: output toggles every cycle
    step(1'b1, 1'b1, WIDTH'(0));
    idle_steps(1'b1, 30);

    // Disable with a pending divisor, then re-enable
    step(1'b1, 1'b1, WIDTH'(9));
    step(1'b0, 1'b0, WIDTH'(0));
    idle_steps(1'b0, 3);
    idle_steps(1'b1, 45);

    // Maximum divisor is accepted and applied without overflow
    step(1'b1, 1'b1, {WIDTH{1'b1}});
    idle_steps(1'b1, 60);
    step(1'b0, 1'b0, WIDTH'(0));

    // Reset while a divisor is pending discards it
    step(1'b1, 1'b1, WIDTH'(7));
    step(1'b1, 1'b0, WIDTH'(0));
    do_reset();
    check("reset_active_m", 64'(active_m), 64'(DEFAULT_M));
    idle_steps(1'b0, 3);

    // Transfer while disabled and enable dropping with a transfer
    step(1'b0, 1'b1, WIDTH'(3));
    idle_steps(1'b1, 20);
    step(1'b0, 1'b1, WIDTH'(2));
    idle_steps(1'b1, 20);

    // Random traffic with small divisors, including boundary-cycle transfers
    for (int i = 0; i < 20000; i++) begin
      bit               en;
      bit               v;
      logic [WIDTH-1:0] cm;
      en = ($urandom_range(0, 99) < 94);
      v  = ($urandom_range(0, 99) < 25);
      cm = WIDTH'($urandom_range(0, 6));
      step(en, v, cm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
Run-time controller for the board's programmable clock divider. It owns the divide counter and the active divisor `m`, and drives `desired_clock` from `basys_clock` (100 MHz). It accepts new divisor values through a valid/ready handshake and applies them only at a full-period boundary, so the output never produces a runt or stretched half-period. Consumers (audio sampler at 20 kHz, display refresh, debouncers) take either `desired_clock` or the single-cycle `tick` strobe.

Parameters:
WIDTH, 32, width of divisor and internal counter
DEFAULT_M, 2499, divisor loaded at reset (20 kHz output from 100 MHz)

Ports:
basys_clock  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  run divider when 1; hold output low when 0
cfg_m  in  WIDTH  requested divisor
cfg_valid  in  1  cfg_m valid this cycle
cfg_ready  out  1  controller can accept a divisor this cycle
active_m  out  WIDTH  divisor currently in effect
desired_clock  out  1  divided clock; half-period = active_m+1 cycles
tick  out  1  one-cycle pulse in first cycle desired_clock is high
cfg_pending  out  1  a divisor is accepted but not yet applied

Behaviour:
- Reset (async, active-high) values:
  - count=0, desired_clock=0, tick=0.
  - active_m=DEFAULT_M, cfg_pending=0, cfg_ready=1.
  - Any pending divisor is discarded.
  - State=IDLE.
- All outputs are registered.
- States:
  - IDLE: enable=0. count held 0, desired_clock held 0, tick=0.
  - RUN: enable=1, no divisor pending.
  - PEND: enable=1, divisor latched, waiting for boundary.
- RUN/PEND counting:
  - If count==active_m: count<=0 and desired_clock toggles. Otherwise count<=count+1.
  - Output period is 2*(active_m+1) cycles.
- tick: asserted in exactly the cycle desired_clock first reads 1 after a 0->1 toggle, then deasserted next cycle.
- Handshake:
  - cfg_ready = !cfg_pending.
  - Transfer occurs when cfg_valid && cfg_ready at a rising edge. The controller latches cfg_m into pending_m, and cfg_pending<=1 on the next cycle.
  - cfg_m is ignored when no transfer occurs.
- Apply rule:
  - In RUN/PEND, pending_m is applied at the edge where desired_clock toggles 1->0 (end of full period). At that edge: active_m<=pending_m, count<=0, cfg_pending<=0.
  - The following low half uses the new divisor.
  - In IDLE, pending_m is applied on the cycle after acceptance.
- Transitions:
  - IDLE->RUN on enable=1. The first rising toggle occurs active_m+1 cycles later.
  - RUN->PEND on transfer while enabled.
  - PEND->RUN on apply.
  - Any state ->IDLE on enable=0: immediate. count<=0, desired_clock<=0, tick<=0. A pending divisor is applied in that same cycle.
- Simultaneous events:
  - Transfer in the same cycle as a 1->0 boundary: not applied at that boundary; waits for the next full-period boundary.
  - enable falling in the same cycle as a transfer: the divisor is accepted and applied in the next cycle, in IDLE.
- Boundaries:
  - cfg_m=0 is legal: desired_clock toggles every cycle (50 MHz); tick is high every other cycle.
  - cfg_m=2^WIDTH-1 is legal. No overflow: count never exceeds active_m because changes apply only with count reset.
- Reset mid-PEND: pending divisor lost, active_m=DEFAULT_M.

Test Plan:
- Reset release, enable=1, no cfg → desired_clock first rises at cycle 2500. Period is 5000 cycles (20 kHz). tick is high 1 cycle per period. active_m=2499.
- At cycle 1000 of a low half, send cfg_m=4 → cfg_ready drops next cycle. The old divisor completes its high half. After the 1->0 toggle, the period is 10 cycles, active_m=4, cfg_pending=0.
- cfg_m=0 while running → after the boundary, desired_clock alternates every cycle and tick is high every 2nd cycle.
- enable=0 mid-high-half with a pending cfg_m=9 → desired_clock=0 next cycle and active_m=9. Re-enable → first rise after 10 cycles.
- Transfer cfg_m=1 in the exact cycle of a 1->0 toggle → the old period repeats once, then the period is 4.
- Assert reset with cfg_pending=1 and cfg_m=7 latched → all outputs at reset values, active_m=2499, cfg_ready=1 and the divisor never applied.
